// File: rtl/main_mem_responder.sv
// main_mem_responder: block memory serving I-cache reads and D-cache reads/writes with fixed latency; ports CLK/RESET(sync active-low), I_* read port, D_* read/write port, STAT_* counters (macro MAIN_MEM_STATS_EN)
module main_mem_responder #(
  parameter int LATENCY = 5,
  parameter int BLOCKS  = 256,
  parameter int ADDR_W  = 28
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_READ,
  input  logic [ADDR_W-1:0] I_ADDRESS,
  output logic [127:0]      I_READDATA,
  output logic              I_BUSYWAIT,
  input  logic              D_READ,
  input  logic              D_WRITE,
  input  logic [ADDR_W-1:0] D_ADDRESS,
  input  logic [127:0]      D_WRITEDATA,
  output logic [127:0]      D_READDATA,
  output logic              D_BUSYWAIT,
  output logic [31:0]       STAT_IREADS,
  output logic [31:0]       STAT_DACCESS,
  output logic [31:0]       STAT_STALLS
);
  localparam int IW = $clog2(BLOCKS);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_n;
  logic owner_d, wr;
  logic [IW-1:0] idx;
  logic [127:0] wdata;
  logic [7:0] cnt;
  logic [127:0] mem [BLOCKS];
  logic d_req, start, last;
  logic unused_addr;
  assign unused_addr = ^{I_ADDRESS[ADDR_W-1:IW], D_ADDRESS[ADDR_W-1:IW]};
  assign d_req = D_READ | D_WRITE;
  assign start = state == IDLE && (d_req || I_READ);
  assign last  = state == ACCESS && cnt == 8'(LATENCY - 1);
  assign I_BUSYWAIT = I_READ && !(state == DONE && !owner_d);
  assign D_BUSYWAIT = d_req && !(state == DONE && owner_d);
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (start ? ACCESS : IDLE) : state == ACCESS ? (last ? DONE : ACCESS) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      I_READDATA <= '0;
      D_READDATA <= '0;
    end else begin
      state <= state_n;
      cnt   <= start ? '0 : state == ACCESS ? cnt + 8'd1 : cnt;
      if (last && !wr && owner_d) D_READDATA <= mem[idx];
      if (last && !wr && !owner_d) I_READDATA <= mem[idx];
    end
  end
  // Request latches need no reset: they are only consumed after a fresh start in IDLE.
  always_ff @(posedge CLK) begin
    if (start) begin
      owner_d <= d_req;
      idx     <= d_req ? D_ADDRESS[IW-1:0] : I_ADDRESS[IW-1:0];
      wr      <= D_WRITE;
      wdata   <= D_WRITEDATA;
    end
  end
  // Gating with RESET drops an in-flight write whose final edge coincides with reset.
  always_ff @(posedge CLK) begin
    if (RESET && last && wr) mem[idx] <= wdata;
  end
`ifdef MAIN_MEM_STATS_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      STAT_IREADS  <= '0;
      STAT_DACCESS <= '0;
      STAT_STALLS  <= '0;
    end else begin
      if (state == DONE && !owner_d) STAT_IREADS <= STAT_IREADS + 32'd1;
      if (state == DONE && owner_d) STAT_DACCESS <= STAT_DACCESS + 32'd1;
      if (I_BUSYWAIT || D_BUSYWAIT) STAT_STALLS <= STAT_STALLS + 32'd1;
    end
  end
`else
  assign STAT_IREADS  = '0;
  assign STAT_DACCESS = '0;
  assign STAT_STALLS  = '0;
`endif
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: directed self-checking bench for main_mem_responder
module tb_main_mem_responder;
  localparam int LAT = 5;
`ifdef MAIN_MEM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam logic [127:0] W1 = 128'h44443333_22221111_DEADBEEF_CAFEF00D;
  localparam logic [127:0] W2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] W3 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] W4 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  logic CLK = 0, RESET = 0, I_READ = 0, D_READ = 0, D_WRITE = 0;
  logic [27:0] I_ADDRESS = '0, D_ADDRESS = '0;
  logic [127:0] D_WRITEDATA = '0;
  logic [127:0] I_READDATA, D_READDATA;
  logic I_BUSYWAIT, D_BUSYWAIT;
  logic [31:0] STAT_IREADS, STAT_DACCESS, STAT_STALLS;
  int checks = 0, errors = 0;
  main_mem_responder #(.LATENCY(LAT), .BLOCKS(256), .ADDR_W(28)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .STAT_IREADS(STAT_IREADS), .STAT_DACCESS(STAT_DACCESS), .STAT_STALLS(STAT_STALLS)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_stats(input string tag, input int ir, input int da, input int st);
    check({tag, "_ireads"}, STAT_IREADS, STATS ? ir : 0);
    check({tag, "_daccess"}, STAT_DACCESS, STATS ? da : 0);
    check({tag, "_stalls"}, STAT_STALLS, STATS ? st : 0);
  endtask
  // Called just after a rising edge; returns just after the edge that ends DONE, request dropped.
  task automatic access(input string tag, input bit d, input bit w, input logic [27:0] a,
                        input logic [127:0] wd, input logic [127:0] exp_rd);
    int c;
    if (d) begin
      D_ADDRESS = a; D_WRITEDATA = wd; D_READ = !w; D_WRITE = w;
    end else begin
      I_ADDRESS = a; I_READ = 1;
    end
    for (c = 0; c < 64; c++) begin
      @(negedge CLK);
      if (!(d ? D_BUSYWAIT : I_BUSYWAIT)) break;
      @(posedge CLK); #1;
    end
    check({tag, "_lat"}, c, LAT + 1);
    check({tag, "_data"}, d ? D_READDATA : I_READDATA, exp_rd);
    @(posedge CLK); #1;
    D_READ = 0; D_WRITE = 0; I_READ = 0;
  endtask
  initial begin
    int dl, il, n;
    int lows [2];
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("rst_i_data", I_READDATA, 0);
    check("rst_d_data", D_READDATA, 0);
    check_stats("rst", 0, 0, 0);
    @(posedge CLK); #1;
    RESET = 1;
    @(posedge CLK); #1;
    access("wr3", 1, 1, 28'h0000003, W1, 0);
    access("rd3", 1, 0, 28'h0000003, 0, W1);
    D_ADDRESS = 28'h3; D_READ = 1; I_ADDRESS = 28'h103; I_READ = 1;
    dl = -1; il = -1;
    for (int c = 0; c < 64 && (D_READ || I_READ); c++) begin
      @(negedge CLK);
      if (D_READ && !D_BUSYWAIT) begin
        dl = c;
        check("sim_d_data", D_READDATA, W1);
      end
      if (I_READ && !I_BUSYWAIT) begin
        il = c;
        check("sim_i_data", I_READDATA, W1);
      end
      @(posedge CLK); #1;
      if (dl == c) D_READ = 0;
      if (il == c) I_READ = 0;
    end
    check("sim_d_lat", dl, LAT + 1);
    check("sim_i_lat", il, 2 * (LAT + 2) - 1);
    @(negedge CLK);
    check_stats("sim", 1, 3, 25);
    @(posedge CLK); #1;
    access("wr105", 1, 1, 28'h0000105, W2, W1);
    access("ird5", 0, 0, 28'h0000005, 0, W2);
    access("wr7", 1, 1, 28'h0000007, W3, W1);
    D_ADDRESS = 28'h7; D_WRITEDATA = W4; D_WRITE = 1;
    repeat (3) begin
      @(posedge CLK); #1;
    end
    RESET = 0; D_WRITE = 0;
    @(posedge CLK); #1;
    RESET = 1;
    @(negedge CLK);
    check("abort_i_data", I_READDATA, 0);
    check("abort_d_data", D_READDATA, 0);
    check("abort_d_busy", D_BUSYWAIT, 0);
    check_stats("abort", 0, 0, 0);
    @(posedge CLK); #1;
    access("rd7", 1, 0, 28'h0000007, 0, W3);
    I_ADDRESS = 28'h203; I_READ = 1;
    n = 0; lows[0] = -1; lows[1] = -1;
    for (int c = 0; c < 64 && n < 2; c++) begin
      @(negedge CLK);
      if (!I_BUSYWAIT) begin
        lows[n] = c;
        check("b2b_data", I_READDATA, W1);
        n++;
      end
      @(posedge CLK); #1;
      if (n == 2) I_READ = 0;
    end
    check("b2b_first", lows[0], LAT + 1);
    check("b2b_gap", lows[1] - lows[0], LAT + 2);
    @(negedge CLK);
    check_stats("end", 2, 1, 18);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
